// File: rtl/display_scan_scheduler_pkg.sv
// Shared definitions for the 6-digit display scanner: slot geometry,
// FSM state encoding, 7-segment codes and small slot helpers.
package display_scan_scheduler_pkg;

  localparam int unsigned NUM_SLOTS       = 6;
  localparam int unsigned SLOTS_PER_GROUP = 3;
  localparam int unsigned SLOT_W          = 3;

  typedef logic [SLOT_W-1:0]    slot_t;
  typedef logic [NUM_SLOTS-1:0] dig_t;
  typedef logic [6:0]           seg_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_e;

  // Active-high segments, bit0 = a ... bit6 = g
  localparam seg_t SEG_0   = 7'h3F;
  localparam seg_t SEG_1   = 7'h06;
  localparam seg_t SEG_2   = 7'h5B;
  localparam seg_t SEG_3   = 7'h4F;
  localparam seg_t SEG_4   = 7'h66;
  localparam seg_t SEG_5   = 7'h6D;
  localparam seg_t SEG_6   = 7'h7D;
  localparam seg_t SEG_7   = 7'h07;
  localparam seg_t SEG_8   = 7'h7F;
  localparam seg_t SEG_9   = 7'h6F;
  localparam seg_t SEG_OFF = 7'h00;

  localparam slot_t LAST_SLOT     = slot_t'(NUM_SLOTS - 1);
  localparam slot_t FIRST_B_SLOT  = slot_t'(SLOTS_PER_GROUP);

  function automatic slot_t slot_next(input slot_t s);
    return (s == LAST_SLOT) ? '0 : s + 1'b1;
  endfunction

  function automatic dig_t slot_onehot(input slot_t s);
    dig_t r;
    r = dig_t'(1);
    return r << s;
  endfunction

endpackage

// File: rtl/bcd_splitter.sv
// Splits an 8-bit binary value (0..255) into hundreds, tens and ones digits.
module bcd_splitter (
  input  logic [7:0] bin,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  // Constant-divisor decimal split
  always_comb begin
    hundreds = 4'(bin / 8'd100);
    tens     = 4'((bin / 8'd10) % 8'd10);
    ones     = 4'(bin % 8'd10);
  end

endmodule

// File: rtl/display_scan_scheduler_bcd_to_seg.sv
// Combinational BCD digit to 7-segment pattern; non-decimal codes are dark.
module bcd_to_seg
  import display_scan_scheduler_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Digit decode table
  always_comb begin
    seg = SEG_OFF;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/display_scan_scheduler.sv
// Scans two snapshotted 8-bit values onto a 6-digit multiplexed 7-segment
// display through one shared decimal splitter, with inter-digit blanking,
// leading-zero suppression and optional blinking of the B group.
module display_scan_scheduler
  import display_scan_scheduler_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] value_a,
  input  logic [7:0] value_b,
  input  logic       blink_b,
  output logic [6:0] seg,
  output logic [5:0] dig,
  output logic       frame_start
);

  localparam int unsigned CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned FRM_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [FRM_W-1:0] FRM_LAST   = FRM_W'(BLINK_FRAMES - 1);
  localparam bit               NO_GAP     = (BLANK_CYCLES == 0);

  state_e           state_q, state_d;
  slot_t            slot_q, slot_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FRM_W-1:0] frm_q, frm_d;
  logic             phase_q, phase_d;
  logic [7:0]       snap_a_q, snap_a_d;
  logic [7:0]       snap_b_q, snap_b_d;
  logic             snap_blink_q, snap_blink_d;
  seg_t             seg_q, seg_d;
  dig_t             dig_q, dig_d;
  logic             frame_start_q, frame_start_d;

  logic       blank_done, dwell_done, frame_wrap, new_frame, enter_show;
  logic [7:0] split_in;
  logic [3:0] d_hund, d_tens, d_ones;
  logic [3:0] digit;
  logic       lz_blank, blink_off;
  seg_t       digit_code, pattern;

  // Phase-end and frame-boundary qualifiers
  always_comb begin
    blank_done = (state_q == BLANK) && (cnt_q == BLANK_LAST);
    dwell_done = (state_q == SHOW)  && (cnt_q == DWELL_LAST);
    frame_wrap = dwell_done && (slot_q == LAST_SLOT);
    new_frame  = en && ((state_q == IDLE) || frame_wrap);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = NO_GAP ? SHOW : BLANK;
        BLANK:   if (blank_done) state_d = SHOW;
        SHOW:    if (dwell_done) state_d = NO_GAP ? SHOW : BLANK;
        default: state_d = IDLE;
      endcase
    end
  end

  // Cycle counter, slot pointer, blink divider and per-frame snapshots
  always_comb begin
    cnt_d        = cnt_q;
    slot_d       = slot_q;
    frm_d        = frm_q;
    phase_d      = phase_q;
    snap_a_d     = snap_a_q;
    snap_b_d     = snap_b_q;
    snap_blink_d = snap_blink_q;
    if (!en) begin
      cnt_d   = '0;
      slot_d  = '0;
      frm_d   = '0;
      phase_d = 1'b0;
    end else begin
      cnt_d = ((state_d != state_q) || dwell_done) ? '0 : cnt_q + 1'b1;
      if (state_q == IDLE)  slot_d = '0;
      else if (dwell_done)  slot_d = slot_next(slot_q);
      if (frame_wrap) begin
        if (frm_q == FRM_LAST) begin
          frm_d   = '0;
          phase_d = ~phase_q;
        end else begin
          frm_d = frm_q + 1'b1;
        end
      end
      if (new_frame) begin
        snap_a_d     = value_a;
        snap_b_d     = value_b;
        snap_blink_d = blink_b;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      slot_q       <= '0;
      frm_q        <= '0;
      phase_q      <= 1'b0;
      snap_a_q     <= '0;
      snap_b_q     <= '0;
      snap_blink_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      slot_q       <= slot_d;
      frm_q        <= frm_d;
      phase_q      <= phase_d;
      snap_a_q     <= snap_a_d;
      snap_b_q     <= snap_b_d;
      snap_blink_q <= snap_blink_d;
    end
  end

  // Pattern is built for the slot about to be lit, from the _d view of
  // slot/snapshot so a gapless slot 0 sees the snapshot taken on that edge.
  always_comb begin
    split_in = (slot_d < FIRST_B_SLOT) ? snap_a_d : snap_b_d;
  end

  bcd_splitter u_bcd_splitter (
    .bin      (split_in),
    .hundreds (d_hund),
    .tens     (d_tens),
    .ones     (d_ones)
  );

  // Digit select with leading-zero and blink suppression
  always_comb begin
    digit    = d_ones;
    lz_blank = 1'b0;
    case (slot_d)
      3'd0, 3'd3: begin
        digit    = d_hund;
        lz_blank = (d_hund == 4'd0);
      end
      3'd1, 3'd4: begin
        digit    = d_tens;
        lz_blank = (d_hund == 4'd0) && (d_tens == 4'd0);
      end
      default: begin
        digit    = d_ones;
        lz_blank = 1'b0;
      end
    endcase
    blink_off = (slot_d >= FIRST_B_SLOT) && snap_blink_d && phase_d;
    pattern   = (lz_blank || blink_off) ? SEG_OFF : digit_code;
  end

  bcd_to_seg u_bcd_to_seg (
    .bcd (digit),
    .seg (digit_code)
  );

  // FSM output logic: outputs follow the state being entered
  always_comb begin
    enter_show    = (state_d == SHOW) && ((state_q != SHOW) || dwell_done);
    seg_d         = seg_q;
    dig_d         = dig_q;
    frame_start_d = new_frame;
    if (state_d != SHOW) begin
      seg_d = SEG_OFF;
      dig_d = '0;
    end else if (enter_show) begin
      seg_d = pattern;
      dig_d = slot_onehot(slot_d);
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q         <= SEG_OFF;
      dig_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      seg_q         <= seg_d;
      dig_q         <= dig_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign dig         = dig_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Directed bench for display_scan_scheduler with DWELL=4, BLANK=2, BLINK=2.
// A frame is 36 cycles: per slot 2 dark cycles then 4 lit cycles.
module tb_display_scan_scheduler;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] value_a;
  logic [7:0] value_b;
  logic       blink_b;
  logic [6:0] seg;
  logic [5:0] dig;
  logic       frame_start;

  int n_checks;
  int n_fail;

  display_scan_scheduler #(
    .DWELL_CYCLES (4),
    .BLANK_CYCLES (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .value_a     (value_a),
    .value_b     (value_b),
    .blink_b     (blink_b),
    .seg         (seg),
    .dig         (dig),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0][6:0] pats(input logic [6:0] s0, s1, s2, s3, s4, s5);
    logic [5:0][6:0] r;
    r[0] = s0; r[1] = s1; r[2] = s2; r[3] = s3; r[4] = s4; r[5] = s5;
    return r;
  endfunction

  // Checks {frame_start, dig, seg} for cycle c (0..35) of a frame
  task automatic check_cycle(input string tag, input int c, input logic [5:0][6:0] exp);
    int          slot;
    int          pos;
    logic [13:0] e;
    logic [5:0]  d;
    slot = c / 6;
    pos  = c % 6;
    d    = 6'b000001 << slot;
    if (pos < 2) e = {(c == 0), 6'b0, 7'h00};
    else         e = {1'b0, d, exp[slot]};
    check_eq($sformatf("%s c%0d", tag, c), {18'b0, frame_start, dig, seg}, {18'b0, e});
  endtask

  // Walks one full frame; optionally changes inputs after checking cycle chg
  task automatic check_frame(input string tag, input logic [5:0][6:0] exp,
                             input int chg, input logic [7:0] na, input logic [7:0] nb,
                             input logic nblink);
    for (int c = 0; c < 36; c++) begin
      check_cycle(tag, c, exp);
      if (c == chg) begin
        value_a = na;
        value_b = nb;
        blink_b = nblink;
      end
      step();
    end
  endtask

  initial begin
    logic [5:0][6:0] f;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    en       = 1'b0;
    value_a  = 8'd0;
    value_b  = 8'd0;
    blink_b  = 1'b0;

    // Reset state
    step(); step();
    check_eq("rst_outputs", {18'b0, frame_start, dig, seg}, 32'd0);
    rst = 1'b0;
    step(); step();
    check_eq("idle_outputs", {18'b0, frame_start, dig, seg}, 32'd0);

    // 255 / 7, then mid-frame change of A to 100
    value_a = 8'd255;
    value_b = 8'd7;
    en      = 1'b1;
    step();
    f = pats(7'h5B, 7'h6D, 7'h6D, 7'h00, 7'h00, 7'h07);
    check_frame("f255_7", f, -1, 8'd255, 8'd7, 1'b0);
    check_frame("f255_chg", f, 8, 8'd100, 8'd7, 1'b0);
    f = pats(7'h06, 7'h3F, 7'h3F, 7'h00, 7'h00, 7'h07);
    check_frame("f100_7", f, 8, 8'd0, 8'd7, 1'b0);
    f = pats(7'h00, 7'h00, 7'h3F, 7'h00, 7'h00, 7'h07);
    check_frame("f0_7", f, 8, 8'd105, 8'd40, 1'b0);
    f = pats(7'h06, 7'h3F, 7'h6D, 7'h00, 7'h66, 7'h3F);
    check_frame("f105_40", f, -1, 8'd105, 8'd40, 1'b0);

    // Drop en mid-SHOW of slot 4
    for (int c = 0; c < 27; c++) begin
      check_cycle("f_drop", c, f);
      if (c < 26) step();
    end
    en = 1'b0;
    step();
    check_eq("en_drop_1", {18'b0, frame_start, dig, seg}, 32'd0);
    step(); step();
    check_eq("en_drop_3", {18'b0, frame_start, dig, seg}, 32'd0);

    // Re-enable with blink on B = 123
    value_b = 8'd123;
    blink_b = 1'b1;
    en      = 1'b1;
    step();
    f = pats(7'h06, 7'h3F, 7'h6D, 7'h06, 7'h5B, 7'h4F);
    check_frame("blk_f0", f, -1, 8'd105, 8'd123, 1'b1);
    check_frame("blk_f1", f, -1, 8'd105, 8'd123, 1'b1);
    f = pats(7'h06, 7'h3F, 7'h6D, 7'h00, 7'h00, 7'h00);
    check_frame("blk_f2", f, -1, 8'd105, 8'd123, 1'b1);
    check_frame("blk_f3", f, -1, 8'd105, 8'd123, 1'b1);
    f = pats(7'h06, 7'h3F, 7'h6D, 7'h06, 7'h5B, 7'h4F);
    check_frame("blk_f4", f, -1, 8'd105, 8'd123, 1'b1);
    check_frame("blk_f5", f, 8, 8'd105, 8'd123, 1'b0);
    check_frame("noblk_f6", f, -1, 8'd105, 8'd123, 1'b0);

    // Asynchronous reset during SHOW of slot 0
    for (int c = 0; c < 4; c++) begin
      check_cycle("f_prerst", c, f);
      if (c < 3) step();
    end
    #2 rst = 1'b1;
    #1 check_eq("rst_mid_show", {18'b0, frame_start, dig, seg}, 32'd0);
    #1 rst = 1'b0;
    check_eq("rst_released", {18'b0, frame_start, dig, seg}, 32'd0);
    step();
    check_frame("post_rst", f, -1, 8'd105, 8'd123, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
